// File: rtl/simon_tx_packer.sv
// Serialises a latched result word into the UART TX FIFO one byte per cycle, LSB byte first,
// optionally followed by a CR/LF terminator.
module simon_tx_packer #(
    parameter int unsigned WORD_BYTES  = 16,
    parameter bit          APPEND_CRLF = 1'b1
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*WORD_BYTES-1:0] data_in,
    input  logic                    tx_full,
    output logic                    wr_uart,
    output logic [7:0]              wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CW = $clog2(WORD_BYTES + 2);
    // Count keeps running through the terminator, so CR and LF sit at WORD_BYTES and +1.
    localparam logic [CW-1:0] CntLast = CW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] CntCr   = CW'(WORD_BYTES);
    localparam logic [CW-1:0] CntLf   = CW'(WORD_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StSend, StTerm, StDone} state_e;

    state_e                  state_q;
    logic [8*WORD_BYTES-1:0] sreg_q;
    logic [CW-1:0]           count_q;
    logic                    busy_q;
    logic                    done_q;

    always_comb begin
        wr_uart = reset && !tx_full && ((state_q == StSend) || (state_q == StTerm));
        wr_data = 8'h00;
        unique case (state_q)
            StSend:  wr_data = sreg_q[7:0];
            StTerm:  wr_data = (count_q == CntCr) ? 8'h0D : 8'h0A;
            default: wr_data = 8'h00;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    count_q <= '0;
                    if (start) begin
                        sreg_q  <= data_in;
                        busy_q  <= 1'b1;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (wr_uart) begin
                        sreg_q  <= sreg_q >> 8;
                        count_q <= count_q + 1'b1;
                        if (count_q == CntLast) begin
                            if (APPEND_CRLF) begin
                                state_q <= StTerm;
                            end else begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                StTerm: begin
                    if (wr_uart) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CntLf) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
